// File: rtl/vga_rect_fill_pkg.sv
// Shared constants, state encoding and command record for the rectangle-fill engine.
// Optional abort input is enabled by defining RECT_FILL_ABORT_EN.
package vga_rect_fill_pkg;

  localparam int RES_X      = 320;
  localparam int RES_Y      = 240;
  localparam int MEM_WIDTH  = 8;
  localparam int ADDR_WIDTH = $clog2(RES_X * RES_Y);
  localparam int X_WIDTH    = $clog2(RES_X);
  localparam int Y_WIDTH    = $clog2(RES_Y);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    FILL,
    DONE
  } fill_state_e;

  typedef struct packed {
    logic [X_WIDTH-1:0]   x;
    logic [Y_WIDTH-1:0]   y;
    logic [X_WIDTH-1:0]   w;
    logic [Y_WIDTH-1:0]   h;
    logic [MEM_WIDTH-1:0] color;
  } rect_cmd_t;

endpackage

// File: rtl/vga_rect_fill_if.sv
// Command handshake plus framebuffer write port of the rectangle-fill engine.
// Defining RECT_FILL_ABORT_EN adds the abort request driven by the master.
interface vga_rect_fill_if;
  import vga_rect_fill_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [X_WIDTH-1:0]    cmd_x;
  logic [Y_WIDTH-1:0]    cmd_y;
  logic [X_WIDTH-1:0]    cmd_w;
  logic [Y_WIDTH-1:0]    cmd_h;
  logic [MEM_WIDTH-1:0]  cmd_color;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [MEM_WIDTH-1:0]  din;
  logic                  wen;
  logic                  busy;
  logic                  done;
`ifdef RECT_FILL_ABORT_EN
  logic                  abort;

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, abort,
    input  cmd_ready, mem_addr, din, wen, busy, done
  );
  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, abort,
    output cmd_ready, mem_addr, din, wen, busy, done
  );
`else
  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    input  cmd_ready, mem_addr, din, wen, busy, done
  );
  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    output cmd_ready, mem_addr, din, wen, busy, done
  );
`endif

endinterface

// File: rtl/vga_rect_fill_addr_gen.sv
// Row-walking address generator: registered write address advanced by adders only,
// the single y*RES_X product being taken once at load.
module vga_rect_fill_addr_gen
  import vga_rect_fill_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [X_WIDTH-1:0]    x_start,
  input  logic [X_WIDTH-1:0]    x_stop,
  input  logic [Y_WIDTH-1:0]    y_start,
  input  logic [Y_WIDTH-1:0]    y_stop,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(RES_X);

  logic [X_WIDTH-1:0]    col, x_first, x_last;
  logic [Y_WIDTH-1:0]    row, y_last;
  logic [ADDR_WIDTH-1:0] row_base, load_base;

  assign load_base = ADDR_WIDTH'(y_start) * ROW_STRIDE;
  assign last      = (col == x_last) && (row == y_last);

  // NOTE: sequential state uses <= so every flop samples the pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      col      <= '0;
      row      <= '0;
      x_first  <= '0;
      x_last   <= '0;
      y_last   <= '0;
      row_base <= '0;
      addr     <= '0;
    end else if (load) begin
      col      <= x_start;
      row      <= y_start;
      x_first  <= x_start;
      x_last   <= x_stop;
      y_last   <= y_stop;
      row_base <= load_base;
      addr     <= load_base + ADDR_WIDTH'(x_start);
    end else if (step) begin
      if (col == x_last) begin
        // Wrap to the left edge of the next row; row_base keeps the running y*RES_X.
        col      <= x_first;
        row      <= row + Y_WIDTH'(1);
        row_base <= row_base + ROW_STRIDE;
        addr     <= row_base + ROW_STRIDE + ADDR_WIDTH'(x_first);
      end else begin
        col  <= col + X_WIDTH'(1);
        addr <= addr + ADDR_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/vga_rect_fill.sv
// Rectangle-fill engine: clips a command to the screen and streams one framebuffer write per cycle.
// Defining RECT_FILL_ABORT_EN adds an abort input that retires the command early.
module vga_rect_fill
  import vga_rect_fill_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  vga_rect_fill_if.slave bus
);

  localparam logic [X_WIDTH:0] X_LIMIT = (X_WIDTH + 1)'(RES_X);
  localparam logic [Y_WIDTH:0] Y_LIMIT = (Y_WIDTH + 1)'(RES_Y);

  fill_state_e        state, next_state;
  rect_cmd_t          cmd_q;
  logic               accept, load, step, empty, last, abort_req;
  logic [X_WIDTH:0]   x_sum, x_end;
  logic [Y_WIDTH:0]   y_sum, y_end;
  logic [X_WIDTH-1:0] x_stop;
  logic [Y_WIDTH-1:0] y_stop;

`ifdef RECT_FILL_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  // Clip in one extra bit so x+w / y+h can exceed the screen without wrapping.
  assign x_sum  = {1'b0, cmd_q.x} + {1'b0, cmd_q.w};
  assign y_sum  = {1'b0, cmd_q.y} + {1'b0, cmd_q.h};
  assign x_end  = (x_sum > X_LIMIT) ? X_LIMIT : x_sum;
  assign y_end  = (y_sum > Y_LIMIT) ? Y_LIMIT : y_sum;
  assign x_stop = X_WIDTH'(x_end - (X_WIDTH + 1)'(1));
  assign y_stop = Y_WIDTH'(y_end - (Y_WIDTH + 1)'(1));
  assign empty  = (cmd_q.w == '0) || (cmd_q.h == '0) ||
                  ({1'b0, cmd_q.x} >= X_LIMIT) || ({1'b0, cmd_q.y} >= Y_LIMIT);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // NOTE: every variable of a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept) next_state = SETUP;
      SETUP:   next_state = (empty || abort_req) ? DONE : FILL;
      FILL:    if (last || abort_req) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = rst && (state == IDLE);
    accept        = bus.cmd_ready && bus.cmd_valid;
    load          = (state == SETUP) && !empty && !abort_req;
    step          = (state == FILL);
    bus.busy      = (state == SETUP) || (state == FILL);
    bus.done      = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cmd_q   <= '0;
      bus.din <= '0;
      bus.wen <= 1'b0;
    end else begin
      if (accept) cmd_q <= '{x: bus.cmd_x, y: bus.cmd_y, w: bus.cmd_w,
                             h: bus.cmd_h, color: bus.cmd_color};
      if (load) bus.din <= cmd_q.color;
      bus.wen <= (next_state == FILL);
    end
  end

  vga_rect_fill_addr_gen u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (step),
    .x_start (cmd_q.x),
    .x_stop  (x_stop),
    .y_start (cmd_q.y),
    .y_stop  (y_stop),
    .addr    (bus.mem_addr),
    .last    (last)
  );

endmodule

// File: tb/tb_vga_rect_fill.sv
// Scoreboard bench for vga_rect_fill: a multiply-based reference model predicts each write,
// and per-command timing (first write, done pulse, ready return) is checked against the accept cycle.
module tb_vga_rect_fill;
  import vga_rect_fill_pkg::*;

  typedef struct {
    int addr;
    int color;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vga_rect_fill_if bus ();

  vga_rect_fill dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;
  bit  sb_en  = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: direct y*RES_X+x per pixel, clipped by loop bounds.
  function automatic int push_rect(input int x, input int y, input int w, input int h, input int c);
    int n = 0;
    for (int yy = y; yy < y + h && yy < RES_Y; yy++)
      for (int xx = x; xx < x + w && xx < RES_X; xx++) begin
        exp_q.push_back('{addr: yy * RES_X + xx, color: c});
        n++;
      end
    return n;
  endfunction

  always @(negedge clk) begin : scoreboard
    wr_t e;
    if (rst && sb_en && bus.wen) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_wen", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sb_addr", bus.mem_addr, e.addr);
        check("sb_din", bus.din, e.color);
      end
    end
  end

  task automatic drive_cmd(input int x, input int y, input int w, input int h, input int c);
    bus.cmd_x     = X_WIDTH'(x);
    bus.cmd_y     = Y_WIDTH'(y);
    bus.cmd_w     = X_WIDTH'(w);
    bus.cmd_h     = Y_WIDTH'(h);
    bus.cmd_color = MEM_WIDTH'(c);
    bus.cmd_valid = 1'b1;
  endtask

  // Accept happens at the posedge ending cycle n; expects first wen at n+2, done at n+2+writes.
  task automatic run_cmd(input int x, input int y, input int w, input int h, input int c,
                         input string tag, output int waited);
    int n, exp_n, nw, first_wen, last_wen, done_cyc;
    waited = 0;
    while (!bus.cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_ready"}, bus.cmd_ready, 1);
    exp_n = push_rect(x, y, w, h, c);
    drive_cmd(x, y, w, h, c);
    n = cyc;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    nw = 0; first_wen = -1; last_wen = -1; done_cyc = -1;
    for (int i = 0; i < 2000 && done_cyc < 0; i++) begin
      if (bus.wen) begin
        if (first_wen < 0) first_wen = cyc;
        last_wen = cyc;
        nw++;
      end
      if (bus.done) done_cyc = cyc;
      else @(negedge clk);
    end
    check({tag, "_done_cycle"}, done_cyc - n, 2 + exp_n);
    check({tag, "_writes"}, nw, exp_n);
    if (exp_n > 0) begin
      check({tag, "_first_wen"}, first_wen - n, 2);
      check({tag, "_wen_span"}, last_wen - first_wen + 1, exp_n);
    end
    @(negedge clk);
    check({tag, "_done_pulse"}, bus.done, 0);
    check({tag, "_ready_after"}, bus.cmd_ready, 1);
    check({tag, "_sb_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int waited, nw;
    bus.cmd_valid = 1'b0;
    bus.cmd_x = '0; bus.cmd_y = '0; bus.cmd_w = '0; bus.cmd_h = '0; bus.cmd_color = '0;
`ifdef RECT_FILL_ABORT_EN
    bus.abort = 1'b0;
`endif

    // Reset state
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_wen", bus.wen, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_ready", bus.cmd_ready, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_din", bus.din, 0);
    rst = 1'b1;
    @(negedge clk);
    check("rel_ready", bus.cmd_ready, 1);

    run_cmd(0, 0, 1, 1, 'h30, "single", waited);
    run_cmd(10, 10, 3, 2, 'h0C, "rect3x2", waited);
    run_cmd(318, 238, 5, 5, 'h03, "clip_corner", waited);
    run_cmd(5, 5, 0, 4, 'h11, "empty_w0", waited);
    run_cmd(320, 5, 2, 2, 'h22, "empty_x320", waited);
    check("b2b_accept_wait", waited, 0);
    run_cmd(100, 50, 7, 3, 'hA5, "mid", waited);
    run_cmd(319, 0, 4, 2, 'h7E, "clip_w1", waited);
    run_cmd(3, 239, 2, 9, 'hC3, "clip_h1", waited);

    // Reset in the middle of a 20x20 fill
    sb_en = 1'b0;
    drive_cmd(0, 0, 20, 20, 'h44);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mrst_filling", bus.wen, 1);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_wen", bus.wen, 0);
    check("mrst_busy", bus.busy, 0);
    check("mrst_ready", bus.cmd_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_idle_ready", bus.cmd_ready, 1);
    check("mrst_idle_busy", bus.busy, 0);
    check("mrst_idle_wen", bus.wen, 0);
    sb_en = 1'b1;
    run_cmd(2, 1, 2, 2, 'h55, "after_rst", waited);

`ifdef RECT_FILL_ABORT_EN
    // Abort on the 7th write: that write stands, nothing follows
    sb_en = 1'b0;
    drive_cmd(0, 0, 20, 20, 'h66);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    nw = 0;
    for (int i = 0; i < 100 && nw < 7; i++) begin
      @(negedge clk);
      if (bus.wen) nw++;
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_wen", bus.wen, 0);
    check("abort_done", bus.done, 1);
    repeat (5) begin
      @(negedge clk);
      if (bus.wen) nw++;
    end
    check("abort_writes", nw, 7);
    check("abort_ready", bus.cmd_ready, 1);
    sb_en = 1'b1;
`endif

    check("final_sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
